// File: rtl/cnn_pkg.sv
// Shared defaults and state encoding for the CNN frame driver.
package cnn_pkg;

    localparam int CNN_IMG_SIZE       = 64;
    localparam int CNN_DATA_W         = 32;
    localparam int CNN_OUT_W          = 32;
    localparam int CNN_TIMEOUT_CYCLES = 1000;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/cnn_img_buf.sv
// Image register file: one synchronous write port, a zero-fill strobe and
// a flattened read bus that drives the core input directly.
module cnn_img_buf
    import cnn_pkg::*;
#(
    parameter int IMG_SIZE = CNN_IMG_SIZE,
    parameter int DATA_W   = CNN_DATA_W,
    localparam int AW      = $clog2(IMG_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         fill,
    input  logic [AW:0]                  fill_from,
    output logic [IMG_SIZE*DATA_W-1:0]   img_flat
);

    logic [DATA_W-1:0] mem [IMG_SIZE];

    // Fill covers indices at or above fill_from, so it never collides with the
    // word being written on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IMG_SIZE; i++) begin
            if (rst) begin
                mem[i] <= '0;
            end else if (fill && ((AW+1)'(i) >= fill_from)) begin
                mem[i] <= '0;
            end else if (we && (waddr == AW'(i))) begin
                mem[i] <= wdata;
            end
        end
    end

    for (genvar g = 0; g < IMG_SIZE; g++) begin : g_flat
        assign img_flat[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/cnn_frame_driver.sv
// Host-side initiator for the CNN core: loads a frame, runs the core under a
// watchdog and returns the prediction on a result channel.
module cnn_frame_driver
    import cnn_pkg::*;
#(
    parameter int IMG_SIZE       = CNN_IMG_SIZE,
    parameter int DATA_W         = CNN_DATA_W,
    parameter int OUT_W          = CNN_OUT_W,
    parameter int TIMEOUT_CYCLES = CNN_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_last,
    output logic [IMG_SIZE*DATA_W-1:0]   img_flat,
    output logic                         core_enable,
    input  logic [OUT_W-1:0]             core_value,
    input  logic                         core_done,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [OUT_W-1:0]             res_data,
    output logic                         res_timeout,
    output logic                         res_short,
    output logic                         busy
);

    localparam int CNT_W = $clog2(IMG_SIZE);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = {WD_W{1'b1}};

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd;
    logic             accept, frame_end, short_end, done_hit, wd_hit, res_take;
    logic [CNT_W:0]   fill_from;

    // Valid/ready: a transfer happens on any rising edge where both are high;
    // the producer holds data stable while valid is high and ready is low.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        frame_end  = 1'b0;
        short_end  = 1'b0;
        done_hit   = 1'b0;
        wd_hit     = 1'b0;
        res_take   = 1'b0;
        case (state)
            ST_LOAD: begin
                accept = s_valid && s_ready;
                if (accept && (s_last || (cnt == LAST_IDX))) begin
                    frame_end  = 1'b1;
                    short_end  = s_last && (cnt != LAST_IDX);
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    done_hit   = 1'b1;
                    next_state = ST_RESULT;
                end else if (wd == WD_LIMIT) begin
                    wd_hit     = 1'b1;
                    next_state = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_take   = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            default: next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            cnt         <= '0;
            wd          <= '0;
            s_ready     <= 1'b0;
            core_enable <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            res_short   <= 1'b0;
        end else begin
            state       <= next_state;
            s_ready     <= (next_state == ST_LOAD);
            core_enable <= (next_state == ST_WAIT);
            if (accept) begin
                cnt <= frame_end ? '0 : cnt + CNT_W'(1);
            end
            if (frame_end) begin
                wd <= '0;
            end else if ((state == ST_WAIT) && (wd != WD_MAX)) begin
                wd <= wd + WD_W'(1);
            end
            if (short_end) begin
                res_short <= 1'b1;
            end
            if (done_hit) begin
                res_data    <= core_value;
                res_timeout <= 1'b0;
                res_valid   <= 1'b1;
            end else if (wd_hit) begin
                res_data    <= '0;
                res_timeout <= 1'b1;
                res_valid   <= 1'b1;
            end
            if (res_take) begin
                res_valid   <= 1'b0;
                res_timeout <= 1'b0;
                res_short   <= 1'b0;
            end
        end
    end

    assign busy      = (state != ST_LOAD);
    assign fill_from = {1'b0, cnt} + (CNT_W+1)'(1);

    cnn_img_buf #(
        .IMG_SIZE (IMG_SIZE),
        .DATA_W   (DATA_W)
    ) u_img_buf (
        .clk       (clk),
        .rst       (rst),
        .we        (accept),
        .waddr     (cnt),
        .wdata     (s_data),
        .fill      (short_end),
        .fill_from (fill_from),
        .img_flat  (img_flat)
    );

endmodule

// File: tb/tb_cnn_frame_driver.sv
// Bench for cnn_frame_driver: vector table of frames plus randomized frames,
// with a behavioural core model and an image/result reference model.
module tb_cnn_frame_driver;

    localparam int IMG_SIZE       = 64;
    localparam int DATA_W         = 32;
    localparam int OUT_W          = 32;
    localparam int TIMEOUT_CYCLES = 1000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       s_valid, s_ready, s_last;
    logic [DATA_W-1:0]          s_data;
    logic [IMG_SIZE*DATA_W-1:0] img_flat;
    logic                       core_enable, core_done;
    logic [OUT_W-1:0]           core_value;
    logic                       res_valid, res_ready, res_timeout, res_short, busy;
    logic [OUT_W-1:0]           res_data;

    always #5 clk = ~clk;

    cnn_frame_driver #(
        .IMG_SIZE       (IMG_SIZE),
        .DATA_W         (DATA_W),
        .OUT_W          (OUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .img_flat    (img_flat),
        .core_enable (core_enable),
        .core_value  (core_value),
        .core_done   (core_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .res_short   (res_short),
        .busy        (busy)
    );

    // Core model: raises done for one cycle after core_delay enabled cycles.
    int   core_delay = 0;
    bit   core_on    = 1'b0;
    int   en_cnt     = 0;
    int   en_len     = 0;
    logic model_done = 1'b0;
    logic done_inject = 1'b0;

    assign core_done = model_done | done_inject;

    always @(negedge clk) begin
        if (rst || !core_enable) begin
            if (en_cnt != 0) en_len = en_cnt;
            en_cnt     = 0;
            model_done = 1'b0;
        end else begin
            model_done = core_on && (en_cnt == core_delay);
            en_cnt++;
        end
    end

    typedef struct {
        int          n_words;
        bit          with_last;
        bit          gap;
        int          pix_mode;
        logic [31:0] pix_val;
        int          delay;
        bit          on;
        logic [31:0] value;
        int          stall;
        logic [31:0] exp_data;
        bit          exp_timeout;
        bit          exp_short;
        int          exp_len;
    } vec_t;

    vec_t              vecs[$];
    logic [DATA_W-1:0] model_img [IMG_SIZE];
    int                n_cmp = 0;
    int                n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < IMG_SIZE; i++)
            if (bad < 0 && img_flat[i*DATA_W +: DATA_W] !== model_img[i]) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: word %0d got %0h expected %0h", name, bad,
                     img_flat[bad*DATA_W +: DATA_W], model_img[bad]);
        end
    endtask

    // Reference: the core run lasts delay+1 cycles unless the watchdog ends it first.
    function automatic vec_t with_model(input vec_t v);
        vec_t r;
        bit   finishes;
        r           = v;
        finishes    = v.on && (v.delay + 1 <= TIMEOUT_CYCLES);
        r.exp_timeout = !finishes;
        r.exp_data    = finishes ? v.value : 32'd0;
        r.exp_len     = finishes ? v.delay + 1 : TIMEOUT_CYCLES;
        r.exp_short   = (v.n_words < IMG_SIZE);
        return r;
    endfunction

    task automatic send_frame(input vec_t v, output bit ok);
        int                waited;
        logic [DATA_W-1:0] w;
        ok         = 1'b1;
        core_delay = v.delay;
        core_on    = v.on;
        core_value = v.value;
        for (int i = 0; i < v.n_words; i++) begin
            w = (v.pix_mode == 0) ? v.pix_val : DATA_W'($urandom);
            if (v.gap && (i % 2 == 1)) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = w;
            s_last  = v.with_last && (i == v.n_words - 1);
            waited  = 0;
            while (!s_ready && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (!s_ready) begin
                chk("s_ready_wait", s_ready, 1);
                s_valid = 1'b0;
                ok = 1'b0;
                return;
            end
            @(posedge clk);
            model_img[i] = w;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int i = v.n_words; i < IMG_SIZE; i++) model_img[i] = '0;
        chk("enable_after_last", core_enable, 1);
        chk("s_ready_after_last", s_ready, 0);
        chk("busy_in_wait", busy, 1);
        if (v.delay >= 3) begin
            s_valid = 1'b1;
            s_data  = 32'hDEAD_BEEF;
            repeat (2) begin
                @(negedge clk);
                chk("junk_not_ready", s_ready, 0);
            end
            s_valid = 1'b0;
        end
    endtask

    task automatic collect_result(input vec_t v);
        int waited;
        waited = 0;
        while (!res_valid && waited < TIMEOUT_CYCLES + 100) begin
            @(negedge clk);
            waited++;
        end
        if (!res_valid) begin
            chk("res_valid_wait", res_valid, 1);
            return;
        end
        #1;
        chk("res_data", res_data, v.exp_data);
        chk("res_timeout", res_timeout, v.exp_timeout);
        chk("res_short", res_short, v.exp_short);
        chk("enable_low_in_result", core_enable, 0);
        chk("enable_length", en_len, v.exp_len);
        chk_img("image");
        res_ready = 1'b0;
        for (int k = 0; k < v.stall; k++) begin
            done_inject = (k == 0);
            @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, v.exp_data);
            chk("stall_s_ready", s_ready, 0);
        end
        done_inject = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_valid", res_valid, 0);
        chk("post_timeout", res_timeout, 0);
        chk("post_short", res_short, 0);
        chk("post_s_ready", s_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        send_frame(v, ok);
        if (ok) collect_result(v);
    endtask

    initial begin
        vec_t v;
        vec_t nominal;
        bit   ok;

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        res_ready = 1'b0; core_value = '0;
        for (int i = 0; i < IMG_SIZE; i++) model_img[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_enable", core_enable, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_res_short", res_short, 0);
        chk("rst_busy", busy, 0);
        chk_img("rst_image");
        rst = 1'b0;
        done_inject = 1'b1;
        @(negedge clk);
        done_inject = 1'b0;
        chk("s_ready_after_rst", s_ready, 1);
        chk("load_done_ignored_en", core_enable, 0);
        chk("load_done_ignored_busy", busy, 0);

        // n, last, gap, mode, pix, delay, on, value, stall, exp_data, exp_to, exp_short, exp_len
        nominal = '{64, 1, 0, 0, 32'd1, 20, 1, 32'd64, 0, 32'd64, 0, 0, 21};
        vecs.push_back(nominal);
        vecs.push_back('{10, 1, 0, 0, 32'h5, 5, 1, 32'd9, 1, 32'd9, 0, 1, 6});
        vecs.push_back('{64, 1, 0, 1, 32'd0, 0, 0, 32'h1234, 2, 32'd0, 1, 0, 1000});
        vecs.push_back('{64, 0, 1, 1, 32'd0, 12, 1, 32'hABCD, 15, 32'hABCD, 0, 0, 13});
        vecs.push_back('{64, 1, 0, 1, 32'd0, 999, 1, 32'd7, 1, 32'd7, 0, 0, 1000});
        vecs.push_back('{64, 1, 0, 1, 32'd0, 0, 1, 32'h55, 0, 32'h55, 0, 0, 1});
        for (int r = 0; r < 8; r++) begin
            v.n_words   = $urandom_range(1, IMG_SIZE);
            v.with_last = (v.n_words < IMG_SIZE) ? 1'b1 : 1'($urandom_range(0, 1));
            v.gap       = 1'($urandom_range(0, 1));
            v.pix_mode  = 1;
            v.pix_val   = '0;
            v.delay     = $urandom_range(0, 40);
            v.on        = 1'b1;
            v.value     = $urandom;
            v.stall     = $urandom_range(0, 4);
            vecs.push_back(with_model(v));
        end
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a core run, then a normal frame.
        v = '{64, 1, 0, 1, 32'd0, 3, 0, 32'd0, 0, 32'd0, 1, 0, 1000};
        send_frame(v, ok);
        repeat (5) @(negedge clk);
        chk("pre_rst_enable", core_enable, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < IMG_SIZE; i++) model_img[i] = '0;
        chk("midrst_enable", core_enable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk_img("midrst_image");
        @(negedge clk);
        chk("midrst_s_ready_next", s_ready, 1);
        run_vec(nominal);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_frame_driver.md
Name: cnn_frame_driver

Overview:
- Host-side initiator for the CNN core (cnn_top).
- Accepts an image as a valid/ready word stream and assembles it into a flattened IMG_SIZE-word buffer that drives the core's input_img.
- Holds the core's enable high until the core raises done, then captures value and returns it on a valid/ready result channel.
- A watchdog aborts runs where done never arrives; the result is flagged as a timeout.

Parameters:
- IMG_SIZE, 64: words per image.
- DATA_W, 32: pixel word width.
- OUT_W, 32: core result width.
- TIMEOUT_CYCLES, 1000: maximum cycles in WAIT before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  host pixel word valid.
- s_ready  out  1  driver accepts pixel word.
- s_data  in  DATA_W  pixel word.
- s_last  in  1  final word of frame.
- img_flat  out  IMG_SIZE*DATA_W  image to core; word i at bits [i*DATA_W +: DATA_W].
- core_enable  out  1  enable to core.
- core_value  in  OUT_W  core prediction.
- core_done  in  1  core completion.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes result.
- res_data  out  OUT_W  captured prediction.
- res_timeout  out  1  result is a timeout abort.
- res_short  out  1  frame ended early via s_last.
- busy  out  1  high in any state except LOAD.

Behaviour:
- Reset values (rst=1 at an edge): state LOAD, word counter 0, buffer all zeros, s_ready 0, core_enable 0, res_valid 0, res_data 0, res_timeout 0, res_short 0, busy 0.
- s_ready goes to 1 the first cycle after rst deasserts.
- Reset has priority over every event, including mid-frame or mid-WAIT. The core sees core_enable drop on the same edge.
- LOAD state:
  - s_ready=1.
  - On s_valid&s_ready, write s_data to buffer[cnt] and increment cnt.
  - The frame ends when cnt==IMG_SIZE-1 is written or s_last=1 is accepted, whichever comes first. s_last on word IMG_SIZE-1 is not short.
  - Early s_last: remaining words are zero-filled on the transition edge and res_short is latched to 1.
  - A word arriving without s_last after the final word is never accepted, because s_ready drops.
- Transition LOAD->WAIT: on the edge accepting the final word, core_enable becomes 1, s_ready becomes 0, the watchdog clears, and cnt resets to 0.
- Latency: if the final word is accepted at edge N, core_enable=1 from edge N to the edge after done.
- WAIT state:
  - core_enable=1 and the watchdog increments each cycle.
  - If core_done=1 at edge D: res_data<=core_value, res_timeout<=0, core_enable<=0, res_valid<=1, go to RESULT. res_valid is visible in the cycle after D.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with core_done=0: res_data<=0, res_timeout<=1, core_enable<=0, go to RESULT.
  - If done and timeout coincide, done wins.
- RESULT state:
  - res_valid=1 and outputs are stable until res_ready=1.
  - On the handshake edge: res_valid<=0, res_timeout<=0, res_short<=0, s_ready<=1, go to LOAD.
  - The buffer is not cleared between frames. img_flat holds the last image until overwritten.
- core_done asserting in LOAD or RESULT is ignored.
- The watchdog is a $clog2(TIMEOUT_CYCLES+1)-bit counter that saturates, with no wrap.
- cnt is $clog2(IMG_SIZE) bits; IMG_SIZE must be a power of two.

Decomposition:
- Package cnn_pkg holds:
  - IMG_SIZE, DATA_W, OUT_W defaults.
  - State enum/localparams: ST_LOAD, ST_WAIT, ST_RESULT, 2-bit.
- Sub-module cnn_img_buf: IMG_SIZE x DATA_W register file with synchronous write port, zero-fill-from-index strobe, synchronous clear on rst, and flattened read bus.
- FSM, watchdog and result registers live in the top.

Test Plan:
1. Nominal: reset, stream 64 words of value 1 with s_last on word 63, core model asserts done 20 cycles after enable with value 64 -> img_flat all 1s; core_enable high exactly 21 cycles; res_valid with res_data=64, res_timeout=0, res_short=0.
2. Short frame: 10 words of 0x5 with s_last on word 9 -> words 0-9 =5, words 10-63 =0, res_short=1 at result.
3. Timeout: core never asserts done, TIMEOUT_CYCLES=1000 -> res_valid appears with res_timeout=1, res_data=0, core_enable low afterward.
4. Backpressure: s_valid toggled every other cycle, res_ready held 0 for 15 cycles -> no word lost or duplicated; res_data stable during stall; s_ready=0 until the handshake.
5. Reset mid-WAIT: rst=1 for 1 cycle during WAIT -> next cycle core_enable=0, buffer zero, s_ready=1; a new 64-word frame completes normally.
6. Done==timeout collision: done on the final watchdog cycle with value 7 -> res_data=7, res_timeout=0.
